activation_stream_unit: RTL and testbench

- Streaming, multi-lane activation stage; successor to the matrix-diagonal activation layer.
- Takes LANES signed accumulator results per beat from the systolic array drain and applies a per-frame selectable activation.
- Requantises each result to OUT_WIDTH signed, with a 2-stage pipeline and valid/ready backpressure.
- Provides per-lane saturation flags, frame/saturation statistics and a reserved-mode error flag.

---
 rtl/activation_stream_unit.sv | 187 ++++++++++++++++++
 tb/tb_activation_stream_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/activation_stream_unit.sv
// Streaming multi-lane activation stage: scale, activate, requantise with a
// two-deep valid/ready pipeline, per-lane clip flags and frame statistics.
module activation_stream_unit #(
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned SCALE_SHIFT = 8,
    parameter int unsigned LEAK_SHIFT  = 3,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 act_type,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_WIDTH*LANES-1:0]  in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH*LANES-1:0] out_data,
    output logic                       out_last,
    output logic [LANES-1:0]           out_sat,
    output logic [CNT_WIDTH-1:0]       frames_done,
    output logic [CNT_WIDTH-1:0]       sat_events,
    output logic                       cfg_err
);

    localparam logic [2:0] MODE_IDENT = 3'b000;
    localparam logic [2:0] MODE_RELU  = 3'b001;
    localparam logic [2:0] MODE_LEAKY = 3'b010;
    localparam logic [2:0] MODE_HSIG  = 3'b011;
    localparam logic [2:0] MODE_HTANH = 3'b100;

    // One extra bit so the sigmoid offset and negation cannot overflow before clamping.
    localparam int unsigned XW = IN_WIDTH + 1;
    localparam logic signed [XW-1:0] OMAX = XW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [XW-1:0] OMIN = -OMAX - XW'(1);
    localparam logic signed [XW-1:0] HALF = XW'(2 ** (OUT_WIDTH - 2));

    logic                       en, in_fire, out_fire;
    logic                       act_rsvd;
    logic [2:0]                 act_dec, beat_mode, mode_q;
    logic                       frame_start_q, cfg_err_q;

    logic                       v1_q, last1_q;
    logic [2:0]                 mode1_q;
    logic [IN_WIDTH*LANES-1:0]  s1_d, s1_q;

    logic                       v2_q, last2_q;
    logic [OUT_WIDTH*LANES-1:0] data2_d, data2_q;
    logic [LANES-1:0]           sat2_d, sat2_q;

    logic signed [XW-1:0]       w, p, lo, hi;
    logic [CNT_WIDTH:0]         pop, sat_sum;
    logic [CNT_WIDTH-1:0]       frames_q, sat_events_q;

    assign en       = out_ready || !v2_q;
    assign in_ready = en;
    assign in_fire  = in_valid && en;
    assign out_fire = v2_q && out_ready;

    assign act_rsvd  = act_type > MODE_HTANH;
    assign act_dec   = act_rsvd ? MODE_IDENT : act_type;
    // The first beat of a frame uses the live act_type; later beats the latched one.
    assign beat_mode = frame_start_q ? act_dec : mode_q;

    // Frame tracking, mode latch and sticky reserved-mode flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q        <= MODE_RELU;
            frame_start_q <= 1'b1;
            cfg_err_q     <= 1'b0;
        end else if (in_fire) begin
            frame_start_q <= in_last;
            if (frame_start_q) begin
                mode_q <= act_dec;
                if (act_rsvd) cfg_err_q <= 1'b1;
            end
        end
    end

    // Stage 1 input: sign-preserving scale of every lane
    always_comb begin
        s1_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            s1_d[k*IN_WIDTH +: IN_WIDTH] = $signed(in_data[k*IN_WIDTH +: IN_WIDTH]) >>> SCALE_SHIFT;
        end
    end

    // Stage 1 register: scaled lanes with their frame marker and mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            mode1_q <= MODE_RELU;
            s1_q    <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                last1_q <= in_last;
                mode1_q <= beat_mode;
                s1_q    <= s1_d;
            end
        end
    end

    // Activation and clamp per lane; sat flags any lane pulled back into range
    always_comb begin
        data2_d = '0;
        sat2_d  = '0;
        w       = '0;
        p       = '0;
        lo      = OMIN;
        hi      = OMAX;
        for (int unsigned k = 0; k < LANES; k++) begin
            w  = XW'($signed(s1_q[k*IN_WIDTH +: IN_WIDTH]));
            p  = w;
            lo = OMIN;
            hi = OMAX;
            case (mode1_q)
                MODE_RELU:  p = w[XW-1] ? '0 : w;
                MODE_LEAKY: p = w[XW-1] ? (w >>> LEAK_SHIFT) : w;
                MODE_HSIG: begin
                    p  = (w >>> 1) + HALF;
                    lo = '0;
                end
                MODE_HTANH: lo = -OMAX;
                default:    p = w;
            endcase
            if (p < lo) begin
                sat2_d[k] = 1'b1;
                data2_d[k*OUT_WIDTH +: OUT_WIDTH] = lo[OUT_WIDTH-1:0];
            end else if (p > hi) begin
                sat2_d[k] = 1'b1;
                data2_d[k*OUT_WIDTH +: OUT_WIDTH] = hi[OUT_WIDTH-1:0];
            end else begin
                data2_d[k*OUT_WIDTH +: OUT_WIDTH] = p[OUT_WIDTH-1:0];
            end
        end
    end

    // Stage 2 register: output beat, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            data2_q <= '0;
            sat2_q  <= '0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                last2_q <= last1_q;
                data2_q <= data2_d;
                sat2_q  <= sat2_d;
            end
        end
    end

    // Clipped-lane count of the current output beat, with headroom bit for overflow
    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            pop = pop + (CNT_WIDTH + 1)'(sat2_q[k]);
        end
        sat_sum = {1'b0, sat_events_q} + pop;
    end

    // Statistics on output handshake: wrapping frame count, saturating clip count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_q     <= '0;
            sat_events_q <= '0;
        end else if (out_fire) begin
            if (last2_q) frames_q <= frames_q + 1'b1;
            sat_events_q <= sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
        end
    end

    assign out_valid   = v2_q;
    assign out_data    = data2_q;
    assign out_last    = last2_q;
    assign out_sat     = sat2_q;
    assign frames_done = frames_q;
    assign sat_events  = sat_events_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_activation_stream_unit.sv
// Directed bench for activation_stream_unit with hand-computed expected values.
module tb_activation_stream_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   act_type;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [3:0]   out_sat;
    logic [15:0]  frames_done;
    logic [15:0]  sat_events;
    logic         cfg_err;

    int total = 0;
    int bad   = 0;

    activation_stream_unit dut (
        .clk        (clk),
        .rst        (rst),
        .act_type   (act_type),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_sat    (out_sat),
        .frames_done(frames_done),
        .sat_events (sat_events),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pk4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    // One isolated beat: accept, confirm 2-cycle latency, check output, complete handshake.
    task automatic run_beat(input string tag, input logic [2:0] act, input logic [127:0] data,
                            input logic last, input logic [31:0] exp_data,
                            input logic [3:0] exp_sat);
        act_type = act;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_sat"}, out_sat, exp_sat);
        check({tag, "_last"}, out_last, last);
        tick();
    endtask

    function automatic logic [127:0] bp_in(input int i);
        return pk4((4 * i) * 256, (4 * i + 1) * 256, (4 * i + 2) * 256, (4 * i + 3) * 256);
    endfunction

    function automatic logic [31:0] bp_out(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        int sent;
        int rcvd;
        logic fire_in;

        rst       = 1'b0;
        act_type  = 3'b000;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frames", frames_done, 16'd0);
        check("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ReLU: lanes 5, 0, 127 (clipped from 256), 0
        run_beat("relu", 3'b001, pk4(1280, -256, 65536, 0), 1'b1, 32'h007F0005, 4'b0100);
        check("relu_sat_events", sat_events, 16'd1);
        check("relu_frames", frames_done, 16'd1);

        // Leaky ReLU: s = -8, -1, 2, -128 -> -1, -1, 2, -16
        run_beat("leaky", 3'b010, pk4(-2048, -256, 512, -32768), 1'b1, 32'hF002FFFF, 4'b0000);

        // Hard sigmoid: s = 0, 200, -200, 20 -> 64, 127, 0, 74
        run_beat("hsig", 3'b011, pk4(0, 51200, -51200, 5120), 1'b1, 32'h4A007F40, 4'b0110);
        check("hsig_sat_events", sat_events, 16'd3);

        // Hard tanh: s = -256, 256, 10, -10 -> -127, 127, 10, -10
        run_beat("htanh", 3'b100, pk4(-65536, 65536, 2560, -2560), 1'b1, 32'hF60A7F81, 4'b0011);
        check("htanh_sat_events", sat_events, 16'd5);
        check("htanh_frames", frames_done, 16'd4);

        // Backpressure: 8-beat identity frame, out_ready low for the first 5 cycles
        sent = 0;
        rcvd = 0;
        act_type = 3'b000;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 8);
            in_data   = bp_in(sent);
            in_last   = (sent == 7);
            @(negedge clk);
            if (c == 3) begin
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_buffered", sent, 2);
            end
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_data", out_data, bp_out(rcvd));
                check("bp_last", out_last, rcvd == 7);
                rcvd++;
            end
            if (fire_in) sent++;
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("bp_received", rcvd, 8);
        tick();
        check("bp_no_dup", out_valid, 1'b0);
        check("bp_frames", frames_done, 16'd5);

        // Mid-frame mode change: frame stays ReLU, next frame is identity
        run_beat("mf0", 3'b001, pk4(-512, -512, -512, -512), 1'b0, 32'h0, 4'b0000);
        run_beat("mf1", 3'b000, pk4(-512, -512, -512, -512), 1'b0, 32'h0, 4'b0000);
        run_beat("mf2", 3'b000, pk4(-512, -512, -512, -512), 1'b0, 32'h0, 4'b0000);
        run_beat("mf3", 3'b000, pk4(-512, -512, -512, -512), 1'b1, 32'h0, 4'b0000);
        run_beat("nf0", 3'b000, pk4(-512, -512, -512, -512), 1'b1, 32'hFEFEFEFE, 4'b0000);
        check("mf_frames", frames_done, 16'd7);

        // Reserved mode latches as identity and sets the sticky error
        run_beat("rsv0", 3'b111, pk4(256, 256, 256, 256), 1'b0, 32'h01010101, 4'b0000);
        check("rsv_cfg_err", cfg_err, 1'b1);
        run_beat("rsv1", 3'b001, pk4(-256, -256, -256, -256), 1'b0, 32'hFFFFFFFF, 4'b0000);
        check("rsv_cfg_err_sticky", cfg_err, 1'b1);

        // Reset mid-frame with a beat parked at the output
        out_ready = 1'b0;
        act_type  = 3'b001;
        in_data   = pk4(2560, 2560, 2560, 2560);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_cfg_err", cfg_err, 1'b0);
        check("mid_rst_frames", frames_done, 16'd0);
        check("mid_rst_sat_events", sat_events, 16'd0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_no_partial", out_valid, 1'b0);
        // New frame starts fresh: act_type sampled on the first beat after reset
        run_beat("post_rst", 3'b000, pk4(-256, -256, -256, -256), 1'b1, 32'hFFFFFFFF, 4'b0000);
        check("post_rst_frames", frames_done, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
